// File: rtl/multi_cycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control_unit_if
//  Description : Signal bundle between the multi-cycle control unit and the
//                datapath it steers.
//                master : control unit (drives control, reads opcode/zero)
//                slave  : datapath   (drives opcode/zero, reads control)
//  Ports       : opcode[5:0], zero          -- datapath -> control
//                ALUOp[2:0], ALUSrcA, ALUSrcB, PCWre, IRWre, RegWre, mRD,
//                mWR, RegDst[1:0], WrRegDSrc, DBDataSrc, ExtSel,
//                PCSrc[1:0], state[3:0]     -- control -> datapath
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_cycle_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       PCWre;
    logic       IRWre;
    logic       RegWre;
    logic       mRD;
    logic       mWR;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ExtSel;
    logic [1:0] PCSrc;
    logic [3:0] state;

    modport master (
        input  opcode, zero,
        output ALUOp, ALUSrcA, ALUSrcB, PCWre, IRWre, RegWre, mRD, mWR,
               RegDst, WrRegDSrc, DBDataSrc, ExtSel, PCSrc, state
    );

    modport slave (
        output opcode, zero,
        input  ALUOp, ALUSrcA, ALUSrcB, PCWre, IRWre, RegWre, mRD, mWR,
               RegDst, WrRegDSrc, DBDataSrc, ExtSel, PCSrc, state
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control_unit
//  Description : Control FSM for a multi-cycle MIPS-like CPU.
//                IF -> ID -> {EXE->WB | MADDR->MEM(->MWB) | BR | HALT} -> IF
//  Ports       : CLK  - clock, rising edge
//                RST  - synchronous active-high reset
//                bus  - multi_cycle_control_unit_if.master (opcode/zero in,
//                       all control strobes and debug state out)
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_control_unit (
    input  wire logic                       CLK,
    input  wire logic                       RST,
    multi_cycle_control_unit_if.master      bus
);

    typedef enum logic [3:0] {
        S_IF    = 4'b0000,
        S_ID    = 4'b0001,
        S_EXE   = 4'b0010,
        S_WB    = 4'b0011,
        S_MADDR = 4'b0100,
        S_MEM   = 4'b0101,
        S_MWB   = 4'b0110,
        S_BR    = 4'b0111,
        S_HALT  = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t     state_q;
    logic [5:0] op_q;
    logic [5:0] op;

    // The IR is written at the end of IF, so during ID the live opcode is
    // already valid; from EXE onward the copy latched at the end of ID is used.
    assign op = (state_q == S_ID) ? bus.opcode : op_q;

    logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
    logic is_sltiu, is_sw, is_lw, is_beq, is_bne, is_bltz, is_j, is_jr;
    logic is_jal, is_halt;
    logic is_alu, is_mem, is_br, is_jmp, is_rtype;

    assign is_add   = (op == OP_ADD);
    assign is_sub   = (op == OP_SUB);
    assign is_addi  = (op == OP_ADDI);
    assign is_or    = (op == OP_OR);
    assign is_and   = (op == OP_AND);
    assign is_ori   = (op == OP_ORI);
    assign is_sll   = (op == OP_SLL);
    assign is_slt   = (op == OP_SLT);
    assign is_sltiu = (op == OP_SLTIU);
    assign is_sw    = (op == OP_SW);
    assign is_lw    = (op == OP_LW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_bltz  = (op == OP_BLTZ);
    assign is_j     = (op == OP_J);
    assign is_jr    = (op == OP_JR);
    assign is_jal   = (op == OP_JAL);
    assign is_halt  = (op == OP_HALT);

    assign is_rtype = is_add | is_sub | is_or | is_and | is_sll | is_slt;
    assign is_alu   = is_rtype | is_addi | is_ori | is_sltiu;
    assign is_mem   = is_lw | is_sw;
    assign is_br    = is_beq | is_bne | is_bltz;
    assign is_jmp   = is_j | is_jr | is_jal;

    // bltz runs "rs slt $0": a negative rs yields result 1, so zero=0 means taken.
    logic br_taken;
    assign br_taken = (is_beq & bus.zero) | (is_bne & ~bus.zero) | (is_bltz & ~bus.zero);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IF;
            op_q    <= 6'b000000;
        end else begin
            case (state_q)
                S_IF:    state_q <= S_ID;
                S_ID: begin
                    op_q <= bus.opcode;
                    if (is_alu)       state_q <= S_EXE;
                    else if (is_mem)  state_q <= S_MADDR;
                    else if (is_br)   state_q <= S_BR;
                    else if (is_halt) state_q <= S_HALT;
                    else              state_q <= S_IF;   // jumps and undefined
                end
                S_EXE:   state_q <= S_WB;
                S_WB:    state_q <= S_IF;
                S_MADDR: state_q <= S_MEM;
                S_MEM:   state_q <= is_lw ? S_MWB : S_IF;
                S_MWB:   state_q <= S_IF;
                S_BR:    state_q <= S_IF;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    logic [2:0] alu_op;
    logic       alu_src_a, alu_src_b, pc_wre, ir_wre, reg_wre, m_rd, m_wr;
    logic [1:0] reg_dst, pc_src;
    logic       wr_reg_d_src, db_data_src, ext_sel;

    // Strobes are decoded from the current state and gated by RST so that no
    // write can escape while reset is held, even before the reset edge.
    always_comb begin
        alu_op       = 3'b000;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        pc_wre       = 1'b0;
        ir_wre       = 1'b0;
        reg_wre      = 1'b0;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        reg_dst      = 2'b01;
        pc_src       = 2'b00;
        wr_reg_d_src = 1'b1;
        db_data_src  = 1'b0;
        ext_sel      = 1'b1;
        if (!RST) begin
            if (is_sub | is_beq | is_bne)   alu_op = 3'b001;
            else if (is_sltiu)              alu_op = 3'b010;
            else if (is_slt | is_bltz)      alu_op = 3'b011;
            else if (is_sll)                alu_op = 3'b100;
            else if (is_or | is_ori)        alu_op = 3'b101;
            else if (is_and)                alu_op = 3'b110;
            alu_src_a    = is_sll;
            alu_src_b    = is_addi | is_ori | is_sltiu | is_lw | is_sw;
            ext_sel      = ~(is_ori | is_sltiu);
            reg_dst      = is_rtype ? 2'b10 : (is_jal ? 2'b00 : 2'b01);
            wr_reg_d_src = ~is_jal;
            db_data_src  = is_lw;
            case (state_q)
                S_IF:  ir_wre = 1'b1;
                S_ID: begin
                    if (is_jmp) begin
                        pc_wre  = 1'b1;
                        pc_src  = is_jr ? 2'b10 : 2'b11;
                        reg_wre = is_jal;
                    end else if (!(is_alu | is_mem | is_br | is_halt)) begin
                        pc_wre  = 1'b1;                  // undefined opcode: nop
                    end
                end
                S_WB:  begin pc_wre = 1'b1; reg_wre = 1'b1; end
                S_MEM: begin
                    m_rd   = is_lw;
                    m_wr   = ~is_lw;
                    pc_wre = ~is_lw;
                end
                S_MWB: begin pc_wre = 1'b1; reg_wre = 1'b1; end
                S_BR:  begin pc_wre = 1'b1; pc_src = br_taken ? 2'b01 : 2'b00; end
                default: ;
            endcase
        end
    end

    assign bus.ALUOp     = alu_op;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ir_wre;
    assign bus.RegWre    = reg_wre;
    assign bus.mRD       = m_rd;
    assign bus.mWR       = m_wr;
    assign bus.RegDst    = reg_dst;
    assign bus.WrRegDSrc = wr_reg_d_src;
    assign bus.DBDataSrc = db_data_src;
    assign bus.ExtSel    = ext_sel;
    assign bus.PCSrc     = pc_src;
    assign bus.state     = state_q;

endmodule
`default_nettype wire

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port opcode, input, 6 bits: instruction register bits [31:26], stable from the cycle after IF.
REQ-004 The block SHALL have the port zero, input, 1 bit: ALU result==0 flag, valid in the same cycle as the ALUOp that produced it.
REQ-005 The block SHALL have the port ALUOp, output, 3 bits: 000 add, 001 sub, 010 unsigned less-than, 011 signed less-than, 100 shift-left (B<<A), 101 or, 110 and, 111 xnor.
REQ-006 The block SHALL have the ports ALUSrcA and ALUSrcB, output, 1 bit each: ALUSrcA 0=rs, 1=sa; ALUSrcB 0=rt, 1=extended immediate.
REQ-007 The block SHALL have the ports PCWre, IRWre, RegWre, mRD and mWR, output, 1 bit each: PC write, IR write, register-file write, data-memory read and data-memory write enables.
REQ-008 The block SHALL have the port RegDst, output, 2 bits, selecting the write register: 00 $31, 01 rt, 10 rd.
REQ-009 The block SHALL have the port WrRegDSrc, output, 1 bit, selecting write data: 0 PC+4, 1 ALU/memory path.
REQ-010 The block SHALL have the port DBDataSrc, output, 1 bit, selecting the ALU/memory path: 0 ALU result, 1 memory data.
REQ-011 The block SHALL have the port ExtSel, output, 1 bit: 0 zero-extend, 1 sign-extend the immediate.
REQ-012 The block SHALL have the port PCSrc, output, 2 bits, selecting the next PC: 00 PC+4, 01 PC+4+(simm<<2), 10 rs, 11 jump target.
REQ-013 The block SHALL have the port state, output, 4 bits: current FSM state, for debug.

Function
REQ-014 The block SHALL use the state encodings IF=0000, ID=0001, EXE=0010, WB=0011, MADDR=0100, MEM=0101, MWB=0110, BR=0111, HALT=1000.
REQ-015 The block SHALL decode these opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
REQ-016 The block SHALL make the transitions IF->ID unconditionally.
REQ-017 The block SHALL make these transitions out of ID: to EXE for arithmetic/logic/shift/slt; to MADDR for lw/sw; to BR for beq/bne/bltz; to IF for j/jr/jal; to HALT for halt.
REQ-018 The block SHALL make the transitions EXE->WB->IF; MADDR->MEM; MEM->MWB for lw; MEM->IF for sw; MWB->IF; BR->IF.
REQ-019 The block SHALL hold HALT until RST.
REQ-020 The block SHALL treat an undefined opcode in ID as a nop: go to IF with PCWre=1, PCSrc=00 and all writes 0.
REQ-021 The block SHALL drive IRWre=1 only in IF.
REQ-022 The block SHALL drive PCWre=1 only in the last state of an instruction: ID for j/jr/jal/undefined, WB, MWB, MEM for sw, and BR; it SHALL be 0 in HALT.
REQ-023 The block SHALL drive RegWre=1 only in WB, in MWB, and in ID for jal (RegDst=00, WrRegDSrc=0).
REQ-024 The block SHALL drive mRD=1 only in MEM for lw and mWR=1 only in MEM for sw; exactly one of them SHALL be high per MEM cycle.
REQ-025 The block SHALL drive ALUOp from the latched opcode combinationally: add/addi/lw/sw 000, sub/beq/bne 001, sltiu 010, slt/bltz 011, sll 100, or/ori 101, and 110.
REQ-026 The block SHALL drive ALUSrcA=1 only for sll.
REQ-027 The block SHALL drive ALUSrcB=1 for addi, ori, sltiu, lw and sw.
REQ-028 The block SHALL drive ExtSel=0 for ori and sltiu, and 1 otherwise.
REQ-029 The block SHALL drive RegDst=10 for R-type, 01 for I-type and lw, and 00 for jal.
REQ-030 The block SHALL drive DBDataSrc=1 only for lw.
REQ-031 The block SHALL drive PCSrc in BR as 01 when taken, else 00; taken means beq & zero, bne & !zero, or bltz & !zero with the bltz ALU operation rs slt $0.
REQ-032 The block SHALL drive PCSrc=11 for j/jal and 10 for jr, in ID.
REQ-033 The block SHALL make all write enables (PCWre, IRWre, RegWre, mRD, mWR) 0 in any state not listed above.
REQ-034 The block SHALL give the following instruction latencies: R/I-type 4 cycles, lw 5, sw 4, branch 3, j/jr/jal 2.

Reset
REQ-035 The block SHALL set state to IF on the rising edge of CLK with RST=1, regardless of the current state, including HALT and MEM.
REQ-036 The block SHALL, while RST=1, hold PCWre=0, IRWre=0, RegWre=0, mRD=0, mWR=0, ALUOp=000, ALUSrcA=0, ALUSrcB=0 and PCSrc=00.
REQ-037 The block SHALL enter IF with IRWre=1 in the first cycle after RST falls.
REQ-038 The block SHALL abort an instruction when RST is asserted mid-instruction, with no pending write issued after RST falls.

Verification
REQ-039 The bench SHALL cover add (000000): states IF,ID,EXE,WB; ALUOp=000 in EXE; RegWre=1, RegDst=10, PCWre=1 only in WB; next state IF.
REQ-040 The bench SHALL cover lw (110001): states IF,ID,MADDR,MEM,MWB; mRD=1 only in MEM; DBDataSrc=1, RegDst=01, RegWre=1 in MWB; 5 cycles total.
REQ-041 The bench SHALL cover beq with zero=1 in BR (PCSrc=01, PCWre=1) and with zero=0 (PCSrc=00); bne with zero=0 (PCSrc=01).
REQ-042 The bench SHALL cover jal (111010): ID gives PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1; next state IF.
REQ-043 The bench SHALL cover halt (111111): enters HALT, PCWre stays 0 for 10 cycles; RST=1 for 1 cycle -> state=IF, IRWre=1.
REQ-044 The bench SHALL cover RST asserted during the MEM state of sw: mWR=0 from the reset edge; state=IF afterwards.
